// File: rtl/v_mem_pkg.sv
// Shared types and default geometry for the vector memory sequencer.
package v_mem_pkg;

    localparam int VREG_DW_DEF = 256;
    localparam int VREG_AW_DEF = 5;
    localparam int ADDR_W_DEF  = 32;
    localparam int BUS_DW_DEF  = 64;

    // One vector register is moved as NBEATS bus-wide beats.
    localparam int NBEATS     = VREG_DW_DEF / BUS_DW_DEF;
    localparam int BEAT_BYTES = BUS_DW_DEF / 8;
    localparam int BEAT_CW    = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/v_mem_seq.sv
// Vector memory sequencer: moves one vector register to/from the data RAM
// as a series of bus-wide beats and hands load results to writeback.
module v_mem_seq
    import v_mem_pkg::*;
#(
    parameter int VREG_DW = VREG_DW_DEF,
    parameter int VREG_AW = VREG_AW_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int BUS_DW  = BUS_DW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vex_mem_ren_i,
    input  logic               vex_mem_wen_i,
    input  logic [ADDR_W-1:0]  vex_mem_addr_i,
    input  logic [VREG_DW-1:0] vex_mem_wdata_i,
    input  logic [VREG_AW-1:0] vex_wb_addr_i,
    output logic               vram_req_o,
    output logic               vram_we_o,
    output logic [ADDR_W-1:0]  vram_addr_o,
    output logic [BUS_DW-1:0]  vram_wdata_o,
    input  logic               vram_gnt_i,
    input  logic               vram_rvalid_i,
    input  logic [BUS_DW-1:0]  vram_rdata_i,
    output logic               vmem_stall_o,
    output logic               vmem_done_o,
    output logic               vmem_wb_en_o,
    output logic [VREG_AW-1:0] vmem_wb_addr_o,
    output logic [VREG_DW-1:0] vmem_result_o
);

    localparam int NBEATS_L = VREG_DW / BUS_DW;
    localparam int BYTES_L  = BUS_DW / 8;
    localparam int ALIGN_W  = $clog2(BYTES_L);
    localparam int CNT_W    = (NBEATS_L > 1) ? $clog2(NBEATS_L) : 1;

    // Clears the byte-within-beat bits so every beat is bus aligned.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BYTES_L - 1);

    state_e             state_r;
    state_e             state_n_s;
    logic [CNT_W-1:0]   beat_r;
    logic               op_load_r;
    logic [ADDR_W-1:0]  base_r;
    logic [VREG_DW-1:0] wdata_r;
    logic [VREG_AW-1:0] wb_addr_r;
    logic [VREG_DW-1:0] result_r;

    logic               accept_s;
    logic               last_beat_s;
    logic [ADDR_W-1:0]  beat_addr_s;
    logic [BUS_DW-1:0]  beat_wdata_s;

    assign accept_s     = (state_r == ST_IDLE) && (vex_mem_ren_i || vex_mem_wen_i);
    assign last_beat_s  = (beat_r == CNT_W'(NBEATS_L - 1));
    // Natural modulo-2^ADDR_W wrap of the adder gives the required rollover.
    assign beat_addr_s  = base_r + (ADDR_W'(beat_r) << ALIGN_W);
    assign beat_wdata_s = wdata_r[int'(beat_r) * BUS_DW +: BUS_DW];

    // State register with asynchronous abort on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Next-state decode of the beat handshake.
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_n_s = ST_REQ;
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (!vram_gnt_i) begin
                    state_n_s = ST_REQ;
                end else if (op_load_r) begin
                    state_n_s = ST_RESP;
                end else if (last_beat_s) begin
                    state_n_s = ST_DONE;
                end else begin
                    state_n_s = ST_REQ;
                end
            end
            ST_RESP: begin
                if (!vram_rvalid_i) begin
                    state_n_s = ST_RESP;
                end else if (last_beat_s) begin
                    state_n_s = ST_DONE;
                end else begin
                    state_n_s = ST_REQ;
                end
            end
            ST_DONE: state_n_s = ST_IDLE;
            default: state_n_s = ST_IDLE;
        endcase
    end

    // Capture the request so the vector pipeline need not hold its inputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_load_r <= 1'b0;
            base_r    <= '0;
            wdata_r   <= '0;
            wb_addr_r <= '0;
        end else if (accept_s) begin
            // A simultaneous load and store resolves to the load.
            op_load_r <= vex_mem_ren_i;
            base_r    <= vex_mem_addr_i & ALIGN_MASK;
            wdata_r   <= vex_mem_wdata_i;
            wb_addr_r <= vex_wb_addr_i;
        end
    end

    // Beat counter: advances when a beat completes, cleared on the way out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_r <= '0;
        end else begin
            case (state_r)
                ST_REQ: begin
                    if (vram_gnt_i && !op_load_r && !last_beat_s) begin
                        beat_r <= beat_r + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (vram_rvalid_i && !last_beat_s) begin
                        beat_r <= beat_r + CNT_W'(1);
                    end
                end
                ST_DONE: beat_r <= '0;
                default: beat_r <= '0;
            endcase
        end
    end

    // Load assembly: each returned beat lands in its own result slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_r <= '0;
        end else if ((state_r == ST_RESP) && vram_rvalid_i) begin
            result_r[int'(beat_r) * BUS_DW +: BUS_DW] <= vram_rdata_i;
        end
    end

    // Output decode from the registered state; bus fields are quiet outside REQ.
    always_comb begin
        vram_req_o   = 1'b0;
        vram_we_o    = 1'b0;
        vram_addr_o  = '0;
        vram_wdata_o = '0;
        vmem_done_o  = 1'b0;
        vmem_wb_en_o = 1'b0;
        case (state_r)
            ST_REQ: begin
                vram_req_o   = 1'b1;
                vram_we_o    = !op_load_r;
                vram_addr_o  = beat_addr_s;
                vram_wdata_o = beat_wdata_s;
            end
            ST_DONE: begin
                vmem_done_o  = 1'b1;
                vmem_wb_en_o = op_load_r;
            end
            default: begin
                vram_req_o = 1'b0;
            end
        endcase
    end

    // Stall covers the accept cycle so the pipeline freezes with the request.
    assign vmem_stall_o   = (state_r == ST_REQ) || (state_r == ST_RESP) ||
                            ((state_r == ST_IDLE) && (vex_mem_ren_i || vex_mem_wen_i));
    assign vmem_wb_addr_o = wb_addr_r;
    assign vmem_result_o  = result_r;

endmodule

// File: tb/tb_v_mem_seq.sv
// Randomized self-checking bench for v_mem_seq with a behavioural RAM/model.
module tb_v_mem_seq;

    localparam int NB = 4;

    logic         clk;
    logic         rst;
    logic         ren;
    logic         wen;
    logic [31:0]  addr;
    logic [255:0] wdata;
    logic [4:0]   wba;
    logic         req;
    logic         we;
    logic [31:0]  vaddr;
    logic [63:0]  vwdata;
    logic         gnt;
    logic         rvalid;
    logic [63:0]  rdata;
    logic         stall;
    logic         done;
    logic         wb_en;
    logic [4:0]   wb_addr;
    logic [255:0] result;

    int n_checks;
    int n_fail;

    // Model of the architecturally visible load result register.
    logic [255:0] exp_result;

    v_mem_seq dut (
        .clk             (clk),
        .rst             (rst),
        .vex_mem_ren_i   (ren),
        .vex_mem_wen_i   (wen),
        .vex_mem_addr_i  (addr),
        .vex_mem_wdata_i (wdata),
        .vex_wb_addr_i   (wba),
        .vram_req_o      (req),
        .vram_we_o       (we),
        .vram_addr_o     (vaddr),
        .vram_wdata_o    (vwdata),
        .vram_gnt_i      (gnt),
        .vram_rvalid_i   (rvalid),
        .vram_rdata_i    (rdata),
        .vmem_stall_o    (stall),
        .vmem_done_o     (done),
        .vmem_wb_en_o    (wb_en),
        .vmem_wb_addr_o  (wb_addr),
        .vmem_result_o   (result)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Beat k byte address: aligned base plus k beats, wrapping at 2^32.
    function automatic logic [31:0] beat_addr(input logic [31:0] base, input int k);
        logic [63:0] a;
        a = 64'(base - (base % 32'd8)) + 64'(k * 8);
        return a[31:0];
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    // Runs one transfer against the RAM model and checks every cycle.
    task automatic run_txn(input bit ld, input bit st, input logic [31:0] base,
                           input logic [255:0] wd, input logic [4:0] wa,
                           input int gmax, input int rmax, input int hold_beat,
                           input int hold_n, input int exp_lat, input bit stray,
                           input bit pat, input bit poke, input int abort_beat);
        bit   is_load;
        bit   waiting_rv;
        bit   finished;
        int   k;
        int   gw;
        int   rw;
        logic [7:0] b;
        is_load    = ld;
        waiting_rv = 1'b0;
        finished   = 1'b0;
        k          = 0;
        rw         = 0;
        gw         = (hold_beat == 0) ? hold_n : int'($urandom_range(gmax, 0));
        @(negedge clk);
        ren = ld; wen = st; addr = base; wdata = wd; wba = wa;
        #1 check_eq("stall_accept", 256'(stall), 256'(ld | st));
        @(negedge clk);
        for (int cyc = 1; cyc < 150 && !finished; cyc++) begin
            ren = 1'b0; wen = 1'b0; gnt = 1'b0; rvalid = 1'b0; rdata = rnd64();
            addr = $urandom(); wdata = {8{$urandom()}}; wba = 5'($urandom());
            if (k == NB) begin
                check_eq("done", 256'(done), 256'd1);
                check_eq("wb_en", 256'(wb_en), 256'(is_load));
                check_eq("wb_addr", 256'(wb_addr), 256'(wa));
                check_eq("stall_done", 256'(stall), 256'd0);
                check_eq("req_done", 256'(req), 256'd0);
                check_eq("result", result, exp_result);
                if (exp_lat > 0) check_eq("latency", 256'(cyc), 256'(exp_lat));
                finished = 1'b1;
            end else begin
                check_eq("done_early", 256'(done), 256'd0);
                check_eq("stall_busy", 256'(stall), 256'd1);
                if (!waiting_rv) begin
                    check_eq("req", 256'(req), 256'd1);
                    check_eq("beat_addr", 256'(vaddr), 256'(beat_addr(base, k)));
                    check_eq("beat_we", 256'(we), 256'(!is_load));
                    if (!is_load) check_eq("beat_wdata", 256'(vwdata), 256'(wd[k*64 +: 64]));
                    if (poke && cyc == 1) begin
                        ren = 1'b1; wen = 1'b1;
                    end
                    if (gw == 0) begin
                        gnt = 1'b1;
                        if (is_load) begin
                            waiting_rv = 1'b1;
                            rw = int'($urandom_range(rmax, 0));
                        end else begin
                            k++;
                        end
                        if (k < NB) gw = (hold_beat == k) ? hold_n : int'($urandom_range(gmax, 0));
                    end else begin
                        gw--;
                    end
                end else begin
                    check_eq("req_resp", 256'(req), 256'd0);
                    if (k == abort_beat) begin
                        rst = 1'b0;
                        exp_result = '0;
                        #1;
                        check_eq("abort_req", 256'(req), 256'd0);
                        check_eq("abort_stall", 256'(stall), 256'd0);
                        check_eq("abort_result", result, 256'd0);
                        check_eq("abort_done", 256'(done), 256'd0);
                        @(negedge clk);
                        @(negedge clk);
                        rst = 1'b1;
                        @(negedge clk);
                        check_eq("post_abort_done", 256'(done), 256'd0);
                        check_eq("post_abort_req", 256'(req), 256'd0);
                        return;
                    end
                    if (stray) gnt = 1'b1;
                    if (rw == 0) begin
                        rvalid = 1'b1;
                        if (pat) begin
                            b = 8'h11 * 8'(k + 1);
                            rdata = {8{b}};
                        end
                        exp_result[k*64 +: 64] = rdata;
                        waiting_rv = 1'b0;
                        k++;
                    end else begin
                        rw--;
                    end
                end
            end
            @(negedge clk);
        end
        gnt = 1'b0; rvalid = 1'b0;
        if (!finished) begin
            check_eq("timeout", 256'd0, 256'd1);
        end else begin
            check_eq("done_pulse", 256'(done), 256'd0);
            check_eq("wb_en_pulse", 256'(wb_en), 256'd0);
            check_eq("idle_req", 256'(req), 256'd0);
        end
    endtask

    // Directed scenarios followed by randomized transfers.
    initial begin
        logic [255:0] wd;
        n_checks = 0; n_fail = 0; exp_result = '0;
        rst = 1'b0; ren = 1'b0; wen = 1'b0; addr = '0; wdata = '0; wba = '0;
        gnt = 1'b0; rvalid = 1'b0; rdata = '0;
        #12;
        check_eq("rst_req", 256'(req), 256'd0);
        check_eq("rst_we", 256'(we), 256'd0);
        check_eq("rst_addr", 256'(vaddr), 256'd0);
        check_eq("rst_wdata", 256'(vwdata), 256'd0);
        check_eq("rst_stall", 256'(stall), 256'd0);
        check_eq("rst_done", 256'(done), 256'd0);
        check_eq("rst_wb_en", 256'(wb_en), 256'd0);
        check_eq("rst_wb_addr", 256'(wb_addr), 256'd0);
        check_eq("rst_result", result, 256'd0);
        @(negedge clk);
        rst = 1'b1;

        // Back-to-back load with fixed timing and patterned beats.
        run_txn(1'b1, 1'b0, 32'h0000_1000, '0, 5'd5, 0, 0, -1, 0, 9, 1'b0, 1'b1, 1'b0, -1);
        check_eq("pattern_result", exp_result,
                 {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}});

        // Misaligned store, grant withheld 3 cycles on beat 1.
        wd = {{8{8'hDD}}, {8{8'hCC}}, {8{8'hBB}}, {8{8'hAA}}};
        run_txn(1'b0, 1'b1, 32'h0000_2007, wd, 5'd9, 0, 0, 1, 3, 0, 1'b0, 1'b0, 1'b0, -1);

        // Immediate store latency.
        run_txn(1'b0, 1'b1, 32'h0000_3000, {8{$urandom()}}, 5'd1, 0, 0, -1, 0, 5, 1'b0, 1'b0, 1'b0, -1);

        // Top-of-address-space wrap.
        run_txn(1'b1, 1'b0, 32'hFFFF_FFF0, '0, 5'd3, 1, 1, -1, 0, 0, 1'b0, 1'b0, 1'b0, -1);

        // Load and store together, then a re-request during REQ.
        run_txn(1'b1, 1'b1, 32'h0000_4000, {8{$urandom()}}, 5'd12, 0, 0, -1, 0, 9, 1'b0, 1'b0, 1'b1, -1);

        // Stray rvalid while idle, stray gnt during RESP.
        @(negedge clk);
        rvalid = 1'b1; rdata = rnd64(); gnt = 1'b1;
        @(negedge clk);
        rvalid = 1'b0; gnt = 1'b0;
        check_eq("stray_rv_result", result, exp_result);
        check_eq("stray_rv_req", 256'(req), 256'd0);
        check_eq("stray_rv_done", 256'(done), 256'd0);
        run_txn(1'b1, 1'b0, 32'h0000_5000, '0, 5'd7, 2, 2, -1, 0, 0, 1'b1, 1'b0, 1'b0, -1);

        // Reset during RESP of beat 2, then a clean load.
        run_txn(1'b1, 1'b0, 32'h0000_6000, '0, 5'd4, 0, 1, -1, 0, 0, 1'b0, 1'b0, 1'b0, 2);
        run_txn(1'b1, 1'b0, 32'h0000_7000, '0, 5'd6, 0, 0, -1, 0, 9, 1'b0, 1'b0, 1'b0, -1);

        // Randomized traffic.
        for (int i = 0; i < 10; i++) begin
            bit rl;
            bit rs;
            rl = 1'($urandom());
            rs = rl ? 1'($urandom()) : 1'b1;
            run_txn(rl, rs, $urandom(), {8{$urandom()}}, 5'($urandom()), 3, 3, -1, 0, 0,
                    1'($urandom()), 1'b0, 1'($urandom()), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
